de0sopc_jtag_cmd_sync: RTL and testbench
========================================

// Module: de0sopc_jtag_cmd_sync
// PURPOSE
//  Parametrised system-clock side of the Nios II JTAG debug path.
//  - Synchronises the virtual-JTAG update strobes (vs_uir, vs_udr) from the TCK domain into clk.
//  - Captures the IR code and the scan register.
//  - Issues one-hot take_action / take_no_action pulses.
//  - Adds a valid/ready command handshake toward the OCI, with overrun detection and a drop counter.
//  - Sits between the TCK-domain shift logic and the debug-module consumers (break, ocimem, trace).
// PARAMETERS
//  IR_WIDTH     2   width of ir_in; NUM_CMDS = 2**IR_WIDTH (localparam)
//  DATA_WIDTH   38  width of sr / jdo
//  SYNC_STAGES  2   flops in each strobe synchroniser, legal range 2..4
//  ACTION_BIT   34  sr bit selecting action (1) vs no-action (0), must be < DATA_WIDTH
//  CNT_WIDTH    8   width of drop_count
// PORTS
//  clk             in   1           system clock
//  reset_n         in   1           async active-low reset
//  vs_uir          in   1           TCK-domain update-IR level, asynchronous to clk
//  vs_udr          in   1           TCK-domain update-DR level, asynchronous to clk
//  ir_in           in   IR_WIDTH    IR code, stable around vs_uir
//  sr              in   DATA_WIDTH  scan register, stable around vs_udr
//  cmd_ready       in   1           consumer accepts the command
//  overrun_clr     in   1           clears overrun and drop_count
//  ir_q            out  IR_WIDTH    last captured IR
//  jdo             out  DATA_WIDTH  captured scan data, stable while cmd_valid
//  cmd_ir          out  IR_WIDTH    IR of the pending command
//  cmd_valid       out  1           command pending
//  take_action     out  NUM_CMDS    one-clk one-hot pulse, index = cmd_ir, sr[ACTION_BIT]=1
//  take_no_action  out  NUM_CMDS    same, for sr[ACTION_BIT]=0
//  overrun         out  1           sticky: a command was dropped
//  drop_count      out  CNT_WIDTH   saturating count of dropped commands
// BEHAVIOUR
//  Reset values:
//  - All outputs 0.
//  - Synchroniser chains and edge-detect flops reset to 1, so a strobe held high across reset release produces no pulse.
//  Synchronisation and capture:
//  - Each strobe passes a SYNC_STAGES flop chain; udr_p / uir_p = rising edge of the last stage (1 clk wide).
//  - Latency: jdo/cmd_valid update on the (SYNC_STAGES+1)th clk edge, counting the first edge that samples vs_udr=1.
//  - uir_p: ir_q <= ir_in.
//  - udr_p: the capture uses the ir_q value held before any same-cycle uir_p update.
//  FSM with two states, IDLE and PEND:
//  - IDLE, udr_p: jdo<=sr, cmd_ir<=ir_q, cmd_valid<=1, pulse fires -> PEND.
//  - PEND, cmd_ready & !udr_p: cmd_valid<=0 -> IDLE.
//  - PEND, cmd_ready & udr_p: old command accepted; new one loaded in the same edge with a new pulse; stay in PEND.
//  - PEND, !cmd_ready & udr_p: new command dropped; jdo/cmd_ir unchanged; overrun<=1; drop_count+1, saturating at all-ones; no pulse.
//  - cmd_ready in IDLE is ignored.
//  Pulses:
//  - take_action / take_no_action are registered and high exactly the one clk in which cmd_valid first shows the new command.
//  - Otherwise all zeros; never both vectors nonzero.
//  overrun_clr:
//  - Clears overrun and drop_count.
//  - If a drop occurs in the same cycle, the drop wins: overrun=1, drop_count=1.
//  - No effect on the FSM.
//  Reset mid-operation: pending command discarded, no pulse; inputs sampled afresh after release.
//  Width rules: drop_count unsigned, no wrap; ir_in/sr captured verbatim, no truncation.
// TESTING
//  1. Reset with vs_udr=1, release, hold 20 clk -> cmd_valid=0, no pulses.
//  2. vs_uir pulse with ir_in=2'b01, then vs_udr with sr[34]=1, cmd_ready=1 -> on edge 3 after sampled rise:
//     take_action=4'b0010 for 1 clk, cmd_valid for 1 clk, jdo=sr.
//  3. cmd_ready=0; two vs_udr commands (sr=A, then B) -> jdo stays A; overrun=1; drop_count=1; single pulse only.
//  4. cmd_ready rises in the same cycle as the second udr_p -> A accepted, B loaded, second pulse, overrun=0.
//  5. 300 drops with CNT_WIDTH=8 -> drop_count=255; overrun_clr -> 0.
//  6. Assert reset_n=0 while PEND -> cmd_valid=0 immediately; after release, no stale pulse.

Source files
------------

// File: rtl/de0sopc_jtag_cmd_sync.sv
// System-clock side of the JTAG debug path: synchronises update strobes, captures IR/scan data, issues command pulses.
// Latency: jdo/cmd_valid/pulse update on the (SYNC_STAGES+1)th clk edge after vs_udr is first sampled high.
// Backpressure: one command slot; a new command arriving while the slot is held and cmd_ready is low is dropped and counted.
module de0sopc_jtag_cmd_sync #(
  parameter int IR_WIDTH    = 2,
  parameter int DATA_WIDTH  = 38,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = 34,
  parameter int CNT_WIDTH   = 8,
  localparam int NUM_CMDS   = 2**IR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vs_uir,
  input  logic                  vs_udr,
  input  logic [IR_WIDTH-1:0]   ir_in,
  input  logic [DATA_WIDTH-1:0] sr,
  input  logic                  cmd_ready,
  input  logic                  overrun_clr,
  output logic [IR_WIDTH-1:0]   ir_q,
  output logic [DATA_WIDTH-1:0] jdo,
  output logic [IR_WIDTH-1:0]   cmd_ir,
  output logic                  cmd_valid,
  output logic [NUM_CMDS-1:0]   take_action,
  output logic [NUM_CMDS-1:0]   take_no_action,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  // Synchroniser chains; bit SYNC_STAGES-1 is the stage seen by the clk domain.
  logic [SYNC_STAGES-1:0] uir_sync_q;
  logic [SYNC_STAGES-1:0] udr_sync_q;
  logic                   uir_last_q;
  logic                   udr_last_q;
  logic                   uir_p;
  logic                   udr_p;

  logic [IR_WIDTH-1:0]    ir_cap_q;
  logic [DATA_WIDTH-1:0]  jdo_q;
  logic [IR_WIDTH-1:0]    cmd_ir_q;
  logic                   cmd_valid_q;
  logic [NUM_CMDS-1:0]    take_action_q;
  logic [NUM_CMDS-1:0]    take_no_action_q;
  logic                   overrun_q;
  logic [CNT_WIDTH-1:0]   drop_cnt_q;
  logic [CNT_WIDTH-1:0]   drop_cnt_d;
  state_t                 state_q;

  logic                   load_cmd;
  logic                   drop_cmd;
  logic [NUM_CMDS-1:0]    cmd_onehot;

  // Strobe synchronisers; reset to ones so a level already high at release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_q <= '1;
      udr_sync_q <= '1;
      uir_last_q <= 1'b1;
      udr_last_q <= 1'b1;
    end else begin
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_last_q <= uir_sync_q[SYNC_STAGES-1];
      udr_last_q <= udr_sync_q[SYNC_STAGES-1];
    end
  end

  assign uir_p = uir_sync_q[SYNC_STAGES-1] & ~uir_last_q;
  assign udr_p = udr_sync_q[SYNC_STAGES-1] & ~udr_last_q;

  // A strobe is accepted when the slot is free or being vacated this cycle; otherwise it is dropped.
  always_comb begin
    load_cmd   = 1'b0;
    drop_cmd   = 1'b0;
    cmd_onehot = NUM_CMDS'(1) << ir_cap_q;
    if (udr_p) begin
      if ((state_q == S_IDLE) || cmd_ready) begin
        load_cmd = 1'b1;
      end else begin
        drop_cmd = 1'b1;
      end
    end
  end

  // IR capture; the command path reads the value held before this edge's update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_cap_q <= '0;
    end else if (uir_p) begin
      ir_cap_q <= ir_in;
    end
  end

  // Command slot FSM with registered data, valid and one-cycle action pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      jdo_q            <= '0;
      cmd_ir_q         <= '0;
      cmd_valid_q      <= 1'b0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
    end else begin
      take_action_q    <= '0;
      take_no_action_q <= '0;
      if (load_cmd) begin
        state_q     <= S_PEND;
        jdo_q       <= sr;
        cmd_ir_q    <= ir_cap_q;
        cmd_valid_q <= 1'b1;
        if (sr[ACTION_BIT]) begin
          take_action_q    <= cmd_onehot;
        end else begin
          take_no_action_q <= cmd_onehot;
        end
      end else begin
        case (state_q)
          S_PEND: begin
            if (cmd_ready && !udr_p) begin
              state_q     <= S_IDLE;
              cmd_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Saturating drop count; a same-cycle drop overrides a clear and restarts the count at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_cmd) begin
      if (overrun_clr) begin
        drop_cnt_d = CNT_WIDTH'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
    end else if (overrun_clr) begin
      drop_cnt_d = '0;
    end
  end

  // Sticky overrun flag and drop counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (drop_cmd) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign ir_q           = ir_cap_q;
  assign jdo            = jdo_q;
  assign cmd_ir         = cmd_ir_q;
  assign cmd_valid      = cmd_valid_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign overrun        = overrun_q;
  assign drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_de0sopc_jtag_cmd_sync.sv
// Bench for de0sopc_jtag_cmd_sync: directed scenarios followed by random strobe traffic.
// Expected commands come from an event-level model of a single command slot and a scoreboard queue.
// A monitor checks status every cycle and pops the scoreboard on every command pulse.
module tb_de0sopc_jtag_cmd_sync;
  localparam int IRW = 2;
  localparam int DW  = 38;
  localparam int SS  = 2;
  localparam int AB  = 34;
  localparam int CW  = 8;
  localparam int NC  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           vs_uir = 1'b0;
  logic           vs_udr = 1'b1;
  logic [IRW-1:0] ir_in = '0;
  logic [DW-1:0]  sr = '0;
  logic           cmd_ready = 1'b0;
  logic           overrun_clr = 1'b0;
  logic [IRW-1:0] ir_q;
  logic [DW-1:0]  jdo;
  logic [IRW-1:0] cmd_ir;
  logic           cmd_valid;
  logic [NC-1:0]  take_action;
  logic [NC-1:0]  take_no_action;
  logic           overrun;
  logic [CW-1:0]  drop_count;

  always #5 clk = ~clk;

  de0sopc_jtag_cmd_sync #(
    .IR_WIDTH(IRW), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .ACTION_BIT(AB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
    .ir_q(ir_q), .jdo(jdo), .cmd_ir(cmd_ir), .cmd_valid(cmd_valid),
    .take_action(take_action), .take_no_action(take_no_action),
    .overrun(overrun), .drop_count(drop_count)
  );

  typedef struct { int due; logic [DW-1:0] dat; } udr_ev_t;
  typedef struct { int due; logic [IRW-1:0] ir; } uir_ev_t;
  typedef struct { logic [DW-1:0] dat; logic [IRW-1:0] ir; } cmd_t;

  udr_ev_t udr_evq[$];
  uir_ev_t uir_evq[$];
  cmd_t    sb_q[$];

  int             cyc = 0;
  bit             m_busy = 1'b0;
  logic [IRW-1:0] m_ir = '0;
  cmd_t           m_cur;
  int             m_drops = 0;
  bit             m_ovr = 1'b0;
  bit             m_pulse = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a strobe is seen SS+1 edges after it is raised; one command slot.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_ir    = '0;
      m_drops = 0;
      m_ovr   = 1'b0;
      m_pulse = 1'b0;
      udr_evq.delete();
      uir_evq.delete();
      sb_q.delete();
    end else begin
      bit got_udr;
      bit dropped;
      logic [DW-1:0] d;
      cyc++;
      m_pulse = 1'b0;
      got_udr = 1'b0;
      dropped = 1'b0;
      d = '0;
      if (udr_evq.size() > 0 && udr_evq[0].due == cyc) begin
        got_udr = 1'b1;
        d = udr_evq[0].dat;
        void'(udr_evq.pop_front());
      end
      if (got_udr) begin
        if (!m_busy || cmd_ready) begin
          m_cur = '{d, m_ir};
          sb_q.push_back(m_cur);
          m_busy = 1'b1;
          m_pulse = 1'b1;
        end else begin
          dropped = 1'b1;
        end
      end else if (m_busy && cmd_ready) begin
        m_busy = 1'b0;
      end
      if (dropped) begin
        m_ovr = 1'b1;
        m_drops = overrun_clr ? 1 : ((m_drops < CNT_MAX) ? m_drops + 1 : CNT_MAX);
      end else if (overrun_clr) begin
        m_ovr = 1'b0;
        m_drops = 0;
      end
      if (uir_evq.size() > 0 && uir_evq[0].due == cyc) begin
        m_ir = uir_evq[0].ir;
        void'(uir_evq.pop_front());
      end
    end
  end

  // Monitor: status every cycle, scoreboard pop on each command pulse.
  always @(negedge clk) begin
    #1;
    chk("cmd_valid", 64'(cmd_valid), 64'(m_busy));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
    chk("ir_q", 64'(ir_q), 64'(m_ir));
    chk("pulse_present", 64'(|{take_action, take_no_action}), 64'(m_pulse));
    if (take_action != '0 && take_no_action != '0) begin
      chk("pulse_exclusive", 64'({take_action, take_no_action}), 64'(0));
    end
    if (take_action != '0 || take_no_action != '0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 64'({take_action, take_no_action}), 64'(0));
      end else begin
        cmd_t e;
        logic [NC-1:0] oh;
        e = sb_q.pop_front();
        oh = NC'(1) << e.ir;
        chk("cmd_jdo", 64'(jdo), 64'(e.dat));
        chk("cmd_ir", 64'(cmd_ir), 64'(e.ir));
        chk("take_action", 64'(take_action), e.dat[AB] ? 64'(oh) : 64'(0));
        chk("take_no_action", 64'(take_no_action), e.dat[AB] ? 64'(0) : 64'(oh));
      end
    end
    if (m_busy && reset_n) begin
      chk("jdo_hold", 64'(jdo), 64'(m_cur.dat));
      chk("cmd_ir_hold", 64'(cmd_ir), 64'(m_cur.ir));
    end
  end

  // Drivers: called at a falling edge, return at a falling edge.
  task automatic send_udr(input logic [DW-1:0] d, input int hi, input int lo, input bit rdy_at_cap);
    int due;
    sr = d;
    vs_udr = 1'b1;
    due = cyc + SS + 1;
    udr_evq.push_back('{due, d});
    for (int i = 1; i <= hi + lo + SS + 1; i++) begin
      @(negedge clk);
      if (i == hi) vs_udr = 1'b0;
      if (rdy_at_cap && cyc == due - 1) cmd_ready = 1'b1;
    end
  endtask

  task automatic send_uir(input logic [IRW-1:0] ir, input int hi, input int lo);
    ir_in = ir;
    vs_uir = 1'b1;
    uir_evq.push_back('{cyc + SS + 1, ir});
    for (int i = 1; i <= hi + lo + SS + 1; i++) begin
      @(negedge clk);
      if (i == hi) vs_uir = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_dat(input bit act);
    logic [DW-1:0] v;
    v = DW'({$urandom(), $urandom()});
    v[AB] = act;
    return v;
  endfunction

  initial begin
    // Strobe held high across reset release must not produce a command.
    idle(3);
    reset_n = 1'b1;
    idle(20);
    vs_udr = 1'b0;
    idle(SS + 3);

    // Single action command with an immediately ready consumer.
    cmd_ready = 1'b1;
    send_uir(2'b01, 1, 1);
    send_udr(rnd_dat(1'b1), 2, 1, 1'b0);
    idle(4);

    // Consumer stalled: second command dropped, first retained.
    cmd_ready = 1'b0;
    send_udr(rnd_dat(1'b0), 1, 1, 1'b0);
    send_udr(rnd_dat(1'b1), 1, 1, 1'b0);
    idle(3);
    overrun_clr = 1'b1;
    cmd_ready = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    cmd_ready = 1'b0;
    idle(2);

    // Ready rises exactly with the second capture: accept-and-reload.
    send_uir(2'b11, 1, 0);
    send_udr(rnd_dat(1'b1), 1, 1, 1'b0);
    send_udr(rnd_dat(1'b0), 1, 1, 1'b1);
    idle(3);
    cmd_ready = 1'b0;

    // Saturating drop counter, then clear.
    send_uir(2'b10, 1, 0);
    cmd_ready = 1'b1;
    idle(1);
    cmd_ready = 1'b0;
    send_udr(rnd_dat(1'b1), 1, 0, 1'b0);
    for (int k = 0; k < 300; k++) send_udr(rnd_dat(k[0]), 1, 0, 1'b0);
    idle(2);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    idle(2);

    // Reset while a command is pending.
    chk("pend_before_reset", 64'(cmd_valid), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("reset_clears_valid", 64'(cmd_valid), 64'(0));
    @(negedge clk);
    idle(2);
    reset_n = 1'b1;
    idle(20);

    // Random traffic with overlapping IR/DR updates, random ready and clears.
    fork
      for (int k = 0; k < 60; k++)
        send_uir(IRW'($urandom_range(3, 0)), $urandom_range(3, 1), $urandom_range(4, 0));
      for (int k = 0; k < 150; k++)
        send_udr(rnd_dat(1'($urandom_range(1, 0))), $urandom_range(3, 1), $urandom_range(3, 0), 1'b0);
      for (int k = 0; k < 900; k++) begin
        @(negedge clk);
        cmd_ready = ($urandom_range(99, 0) < 40);
        overrun_clr = ($urandom_range(99, 0) < 3);
      end
    join
    overrun_clr = 1'b0;
    cmd_ready = 1'b1;
    idle(12);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
